mult_4xn_seq_accum: RTL and testbench

Sequential shift-accumulate controller that builds a 4 x B_WIDTH product from the team's combinational 4x2 partial-product multiplier. It sits directly downstream of that unit and consumes its 6-bit output. Each cycle it drives one 2-bit multiplier slice out and accumulates the returned product, shifted by 2*slice. The 4x2 unit is external and exact or approximate, so the same controller serves both the exact and the approximate datapath.

---
 rtl/mult_approx_pkg.sv | 27 ++
 rtl/mult_4xn_seq_accum.sv | 99 +++++++++
 tb/tb_mult_4xn_seq_accum.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_approx_pkg.sv
// Shared types and constants for the 4 x N shift-accumulate multiplier family.
`timescale 1ns/1ps
package mult_approx_pkg;

    localparam int A_WIDTH    = 4;
    localparam int PP_B_WIDTH = 2;
    localparam int PP_WIDTH   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_4xn_seq_accum.sv
// Sequential 4 x B_WIDTH multiplier controller: feeds 2-bit slices to an external
// 4x2 partial-product unit and accumulates its returned product, LSB slice first.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one multiplier slice per cycle, N cycles
//   DONE  | result held on out_prod until out_ready
`timescale 1ns/1ps
module mult_4xn_seq_accum
    import mult_approx_pkg::*;
#(
    parameter int B_WIDTH = 8,
    localparam int ACC_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [A_WIDTH-1:0]    in_a,
    input  logic [B_WIDTH-1:0]    in_b,
    output logic [A_WIDTH-1:0]    pp_a,
    output logic [PP_B_WIDTH-1:0] pp_b,
    input  logic [PP_WIDTH-1:0]   pp_prod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_prod,
    output logic                  busy
);

    localparam int N         = B_WIDTH / 2;
    localparam int CNT_WIDTH = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CNT_WIDTH-1:0] LAST_SLICE = CNT_WIDTH'(N - 1);

    state_t                 state;
    state_t                 state_next;
    logic [A_WIDTH-1:0]     a_reg;
    logic [B_WIDTH-1:0]     b_reg;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ACC_WIDTH-1:0]   pp_shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)         state_next = RUN;
            RUN:     if (cnt == LAST_SLICE) state_next = DONE;
            DONE:    if (out_ready)        state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Handshake outputs are masked during reset so an aborted result never shows.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE) && !rst;
        busy      = (state != IDLE) && !rst;
        pp_a      = a_reg;
        pp_b      = (state == RUN) ? b_reg[PP_B_WIDTH-1:0] : '0;
        out_prod  = acc;
    end

    // Slice weight is 4^cnt, i.e. a left shift by 2*cnt; overflow wraps silently.
    assign pp_shifted = ACC_WIDTH'(pp_prod) << {cnt, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc + pp_shifted;
                    b_reg <= b_reg >> PP_B_WIDTH;
                    cnt   <= (cnt == LAST_SLICE) ? '0 : cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_4xn_seq_accum.sv
// Scoreboard bench for mult_4xn_seq_accum with an exact or saturated-63 4x2 model.
`timescale 1ns/1ps
module tb_mult_4xn_seq_accum;

    localparam int B_WIDTH   = 8;
    localparam int ACC_WIDTH = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_a;
    logic [B_WIDTH-1:0]   in_b;
    logic [3:0]           pp_a;
    logic [1:0]           pp_b;
    logic [5:0]           pp_prod;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_prod;
    logic                 busy;
    logic                 approx;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign pp_prod = approx ? 6'd63 : 6'(pp_a * pp_b);

    mult_4xn_seq_accum #(.B_WIDTH(B_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .pp_a      (pp_a),
        .pp_b      (pp_b),
        .pp_prod   (pp_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0d expected none", out_prod);
            end else begin
                check("result", int'(out_prod), exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input int a, input int b, input int s0, input int s1,
                          input int s2, input int s3, input int prod, input int hold);
        int sl[4];
        int n;
        sl[0] = s0; sl[1] = s1; sl[2] = s2; sl[3] = s3;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("idle_before_op", int'(in_ready), 1);
        in_a = 4'(a);
        in_b = 8'(b);
        in_valid = 1'b1;
        exp_q.push_back(prod);
        tick();
        in_valid = 1'b0;
        in_a = 4'(a ^ 5);
        in_b = ~in_b;
        for (int i = 0; i < 4; i++) begin
            check("run_in_ready", int'(in_ready), 0);
            check("run_busy", int'(busy), 1);
            check("run_out_valid", int'(out_valid), 0);
            check("run_pp_a", int'(pp_a), a);
            check("run_pp_b", int'(pp_b), sl[i]);
            tick();
        end
        check("done_out_valid", int'(out_valid), 1);
        check("done_in_ready", int'(in_ready), 0);
        check("done_busy", int'(busy), 1);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid = (h % 2) == 0;
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_out_prod", int'(out_prod), prod);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_pp_b", int'(pp_b), 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("done_out_prod", int'(out_prod), prod);
        tick();
        out_ready = 1'b0;
        check("after_out_valid", int'(out_valid), 0);
        check("after_in_ready", int'(in_ready), 1);
        check("after_busy", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ops_a[3];
        int ops_b[3];
        int exp_res[3];
        int acc_cyc[3];
        int idx;
        int n;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        approx = 1'b0;
        tick();
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pp_a", int'(pp_a), 0);
        check("rst_pp_b", int'(pp_b), 0);
        check("rst_out_prod", int'(out_prod), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        run_op(15, 255, 3, 3, 3, 3, 3825, 0);
        run_op(9, 'hB6, 2, 1, 3, 2, 1638, 0);
        run_op(5, 10, 2, 2, 0, 0, 50, 3);

        // Abort in the second RUN cycle.
        in_a = 4'd12;
        in_b = 8'd200;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("abort_busy", int'(busy), 1);
        tick();
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", int'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy_low", int'(busy), 0);
        check("abort_out_prod", int'(out_prod), 0);
        run_op(3, 4, 0, 1, 0, 0, 12, 0);

        approx = 1'b1;
        run_op(6, 'h5A, 2, 2, 1, 1, 1259, 0);
        approx = 1'b0;

        ops_a   = '{0, 7, 15};
        ops_b   = '{200, 0, 1};
        exp_res = '{0, 0, 15};
        out_ready = 1'b1;
        in_valid = 1'b1;
        idx = 0;
        n = 0;
        while (idx < 3 && n < 100) begin
            if (in_ready) begin
                in_a = 4'(ops_a[idx]);
                in_b = 8'(ops_b[idx]);
                exp_q.push_back(exp_res[idx]);
                acc_cyc[idx] = cycle;
                idx++;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("stream_accepted", idx, 3);
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        check("stream_drained", exp_q.size(), 0);
        if (idx == 3) begin
            check("stream_gap_1", acc_cyc[1] - acc_cyc[0], 6);
            check("stream_gap_2", acc_cyc[2] - acc_cyc[1], 6);
        end
        out_ready = 1'b0;
        tick();
        tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_in_ready", int'(in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
